// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one registered ALU between two valid/ready requesters.
// Each accepted operation is issued to the ALU and answered two cycles later.
module alu_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   any_valid;
    logic   grant_port;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        any_valid  = req0_valid || req1_valid;
        grant_port = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    end

    assign req0_ready = (state == IDLE) && any_valid && !grant_port;
    assign req1_ready = (state == IDLE) && any_valid &&  grant_port;

    // Both response buses share the ALU outputs; only the valid pulse selects the owner.
    assign rsp0_result = alu_result;
    assign rsp1_result = alu_result;
    assign rsp0_zero   = alu_zero;
    assign rsp1_zero   = alu_zero;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_control <= '0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_control <= grant_port ? req1_op : req0_op;
                        alu_in1     <= grant_port ? req1_a  : req0_a;
                        alu_in2     <= grant_port ? req1_b  : req0_b;
                        owner       <= grant_port;
                        last_grant  <= grant_port;
                        busy        <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU captures the held operands at the end of this cycle.
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a registered ALU stub, directed scenarios and a
// randomized run checked against a cycle-count/queue reference model.
module tb_alu_share_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero;
    logic [15:0] alu_in1, alu_in2;
    logic [2:0]  alu_control;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        busy;

    int tests = 0;
    int fails = 0;

    alu_share_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic signed [15:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return a << b[3:0];
            3'd5: return a >> b[3:0];
            3'd6: return sa >>> b[3:0];
            default: return (sa < sb) ? 16'd1 : 16'd0;
        endcase
    endfunction

    // Registered ALU with no reset.
    always @(posedge clock) begin
        alu_result <= alu_fn(alu_control, alu_in1, alu_in2);
        alu_zero   <= (alu_in1 == alu_in2);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        tests++;
        if ({alu_in1, alu_in2, alu_control} !== 35'd0) begin
            fails++;
            $display("FAIL reset_alu got %h/%h/%h want 0/0/0", alu_in1, alu_in2, alu_control);
        end
        tests++;
        if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        drive0(1, 3'd2, 16'd5, 16'd3);
        @(negedge clock);
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        drive0(0, 0, 0, 0);
        @(negedge clock);
        tests++;
        if ({busy, rsp0_valid, alu_control, alu_in1, alu_in2} !== {1'b1, 1'b0, 3'd2, 16'd5, 16'd3}) begin
            fails++;
            $display("FAIL single_exec got busy=%b v=%b op=%0d a=%0d b=%0d want 1 0 2 5 3",
                     busy, rsp0_valid, alu_control, alu_in1, alu_in2);
        end
        tick();
        @(negedge clock);
        tests++;
        if ({rsp0_valid, rsp1_valid, rsp0_result, rsp0_zero} !== {2'b10, 16'd8, 1'b0}) begin
            fails++;
            $display("FAIL single_rsp got v=%b%b res=%h z=%b want 10 0008 0",
                     rsp0_valid, rsp1_valid, rsp0_result, rsp0_zero);
        end
        tick();
        @(negedge clock);
        tests++;
        if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            fails++;
            $display("FAIL single_done got %b want 000", {rsp0_valid, rsp1_valid, busy});
        end
    endtask

    task automatic test_zero();
        logic [2:0]  ops[2] = '{3'd0, 3'd4};
        logic [15:0] as[2]  = '{16'h0007, 16'h0001};
        logic [15:0] bs[2]  = '{16'h0007, 16'h0004};
        logic [15:0] rs[2]  = '{16'h0007, 16'h0010};
        logic        zs[2]  = '{1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive1(1, ops[i], as[i], bs[i]);
            @(negedge clock);
            tests++;
            if ({req0_ready, req1_ready} !== 2'b01) begin
                fails++;
                $display("FAIL zero_ready[%0d] got %b want 01", i, {req0_ready, req1_ready});
            end
            tick();
            drive1(0, 0, 0, 0);
            tick();
            @(negedge clock);
            tests++;
            if ({rsp0_valid, rsp1_valid, rsp1_result, rsp1_zero} !== {2'b01, rs[i], zs[i]}) begin
                fails++;
                $display("FAIL zero_rsp[%0d] got v=%b%b res=%h z=%b want 01 %h %b",
                         i, rsp0_valid, rsp1_valid, rsp1_result, rsp1_zero, rs[i], zs[i]);
            end
            tick();
        end
    endtask

    task automatic test_contention();
        int p;
        do_reset();
        drive0(1, 3'd3, 16'd10, 16'd4);
        drive1(1, 3'd1, 16'h00F0, 16'h000F);
        for (int c = 0; c < 12; c++) begin
            p = (c / 3) % 2;
            @(negedge clock);
            if (c % 3 == 0) begin
                tests++;
                if ({req0_ready, req1_ready} !== {p == 0, p == 1}) begin
                    fails++;
                    $display("FAIL contend_grant[%0d] got %b want port %0d", c,
                             {req0_ready, req1_ready}, p);
                end
            end else if (c % 3 == 2) begin
                tests++;
                if ({rsp0_valid, rsp1_valid} !== {p == 0, p == 1} ||
                    alu_result !== ((p == 1) ? 16'h00FF : 16'd6)) begin
                    fails++;
                    $display("FAIL contend_rsp[%0d] got v=%b%b res=%h want port %0d res %h", c,
                             rsp0_valid, rsp1_valid, alu_result, p,
                             (p == 1) ? 16'h00FF : 16'd6);
                end
            end else begin
                tests++;
                if ({req0_ready, req1_ready} !== 2'b00) begin
                    fails++;
                    $display("FAIL contend_nogrant[%0d] got %b want 00", c, {req0_ready, req1_ready});
                end
            end
            tick();
        end
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_signed();
        logic [2:0]  ops[2] = '{3'd6, 3'd7};
        logic [15:0] as[2]  = '{16'h8000, 16'hFFFF};
        logic [15:0] rs[2]  = '{16'hC000, 16'h0001};
        for (int i = 0; i < 2; i++) begin
            drive0(1, ops[i], as[i], 16'd1);
            tick();
            drive0(0, 0, 0, 0);
            tick();
            @(negedge clock);
            tests++;
            if ({rsp0_valid, rsp0_result} !== {1'b1, rs[i]}) begin
                fails++;
                $display("FAIL signed[%0d] got v=%b res=%h want 1 %h", i, rsp0_valid,
                         rsp0_result, rs[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        drive1(1, 3'd3, 16'd9, 16'd2);
        @(negedge clock);
        tests++;
        if (req1_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_accept got %b want 1", req1_ready);
        end
        tick();
        drive1(0, 0, 0, 0);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if ({busy, rsp1_valid, alu_in1, alu_in2, alu_control} !== 37'd0) begin
            fails++;
            $display("FAIL midrst_clear got busy=%b v=%b a=%h b=%h op=%0d want all 0",
                     busy, rsp1_valid, alu_in1, alu_in2, alu_control);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (rsp0_valid || rsp1_valid) seen++;
            tick();
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL midrst_norsp got %0d pulses want 0", seen);
        end
        drive0(1, 3'd2, 16'd1, 16'd1);
        drive1(1, 3'd2, 16'd2, 16'd2);
        @(negedge clock);
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL midrst_tie got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_late();
        do_reset();
        drive0(1, 3'd2, 16'd1, 16'd1);
        tick();
        drive0(0, 0, 0, 0);
        tick();
        drive1(1, 3'd1, 16'd3, 16'd4);
        @(negedge clock);
        tests++;
        if ({rsp0_valid, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL late_resp got v0=%b rdy1=%b want 1 0", rsp0_valid, req1_ready);
        end
        tick();
        @(negedge clock);
        tests++;
        if (req1_ready !== 1'b1) begin
            fails++;
            $display("FAIL late_accept got %b want 1", req1_ready);
        end
        tick();
        drive1(0, 0, 0, 0);
        @(negedge clock);
        tests++;
        if (rsp1_valid !== 1'b0) begin
            fails++;
            $display("FAIL late_early got %b want 0", rsp1_valid);
        end
        tick();
        @(negedge clock);
        tests++;
        if ({rsp1_valid, rsp1_result, rsp1_zero} !== {1'b1, 16'd7, 1'b0}) begin
            fails++;
            $display("FAIL late_rsp got v=%b res=%h z=%b want 1 0007 0", rsp1_valid,
                     rsp1_result, rsp1_zero);
        end
        tick();
    endtask

    typedef struct {
        int          due;
        logic        port;
        logic [15:0] res;
        logic        z;
    } exp_t;

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic        pend[2];
        logic [2:0]  op[2];
        logic [15:0] a[2], b[2];
        logic        last = 1'b1;
        int          free_at = 0;
        logic        g_any, gp;
        logic        e0, e1;
        int          bad = 0;
        do_reset();
        pend = '{1'b0, 1'b0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[p] = 1'b1;
                        op[p] = 3'($urandom_range(0, 7));
                        a[p]  = 16'($urandom);
                        b[p]  = ($urandom_range(0, 3) == 0) ? a[p] : 16'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[p] = 1'b0;
                end
            end
            drive0(pend[0], op[0], a[0], b[0]);
            drive1(pend[1], op[1], a[1], b[1]);
            @(negedge clock);
            g_any = (cyc >= free_at) && (pend[0] || pend[1]);
            gp    = (pend[0] && pend[1]) ? !last : pend[1];
            tests++;
            if ({req0_ready, req1_ready, busy} !== {g_any && !gp, g_any && gp, cyc < free_at}) begin
                fails++; bad++;
                if (bad < 10)
                    $display("FAIL rand_ready[%0d] got %b want %b", cyc,
                             {req0_ready, req1_ready, busy},
                             {g_any && !gp, g_any && gp, cyc < free_at});
            end
            e0 = 1'b0; e1 = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                e0 = !e.port;
                e1 = e.port;
                tests++;
                if (alu_result !== e.res || rsp0_zero !== e.z || rsp1_zero !== e.z ||
                    rsp0_result !== e.res || rsp1_result !== e.res) begin
                    fails++; bad++;
                    if (bad < 10)
                        $display("FAIL rand_data[%0d] got res=%h z=%b want %h %b", cyc,
                                 alu_result, alu_zero, e.res, e.z);
                end
            end
            tests++;
            if ({rsp0_valid, rsp1_valid} !== {e0, e1}) begin
                fails++; bad++;
                if (bad < 10)
                    $display("FAIL rand_valid[%0d] got %b want %b", cyc,
                             {rsp0_valid, rsp1_valid}, {e0, e1});
            end
            if (g_any) begin
                e.due  = cyc + 2;
                e.port = gp;
                e.res  = alu_fn(op[gp], a[gp], b[gp]);
                e.z    = (a[gp] == b[gp]);
                q.push_back(e);
                free_at = cyc + 3;
                last    = gp;
                pend[gp] = 1'b0;
            end
            tick();
        end
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset_n = 1'b1;
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        test_reset();
        test_single();
        test_zero();
        test_contention();
        test_signed();
        test_reset_mid();
        test_late();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end

endmodule
